fft_stage_sequencer: RTL and testbench

- Sequences a single pipelined radix-2 butterfly unit through a complete in-place 256-point DIT FFT: 8 stages of 128 butterflies each.
- Generates sample-RAM read and write addresses, twiddle-ROM addresses and the butterfly enable.
- Drains the butterfly pipeline between stages to avoid read-after-write hazards.
- Sits between the FFT frame loader, which writes bit-reversed samples into RAM, and the spectral-flux magnitude stage, which starts on o_done.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_stage_sequencer_if.sv | 31 +++
 rtl/fft_addr_gen.sv | 22 ++
 rtl/fft_stage_sequencer.sv | 114 +++++++++++
 tb/tb_fft_stage_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the in-place radix-2 DIT FFT datapath.
package fft_pkg;
    localparam int LOG2N    = 8;
    localparam int N        = 1 << LOG2N;
    localparam int NBF      = N / 2;
    localparam int RD_LAT   = 1;
    localparam int BF_LAT   = 2;
    localparam int PIPE_LAT = RD_LAT + BF_LAT;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef logic [LOG2N-1:0]         addr_t;
    typedef logic [LOG2N-2:0]         tw_addr_t;
    typedef logic [LOG2N-2:0]         k_t;
    typedef logic [$clog2(LOG2N)-1:0] stage_t;

    typedef struct packed {
        addr_t a;
        addr_t b;
    } addr_pair_t;
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Sequencer <-> RAM / butterfly control bundle; master is the sequencer side.
interface fft_stage_sequencer_if;
    import fft_pkg::*;

    logic     i_start;
    logic     o_busy;
    logic     o_done;
    stage_t   o_stage;
    logic     o_rd_en;
    addr_t    o_rd_addr_a;
    addr_t    o_rd_addr_b;
    tw_addr_t o_tw_addr;
    logic     o_bf_en;
    logic     i_bf_valid;
    logic     o_wr_en;
    addr_t    o_wr_addr_a;
    addr_t    o_wr_addr_b;
    logic     o_err;

    modport master (
        input  i_start, i_bf_valid,
        output o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b,
               o_tw_addr, o_bf_en, o_wr_en, o_wr_addr_a, o_wr_addr_b, o_err
    );

    modport slave (
        output i_start, i_bf_valid,
        input  o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b,
               o_tw_addr, o_bf_en, o_wr_en, o_wr_addr_a, o_wr_addr_b, o_err
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Combinational in-place DIT address generator: (stage, butterfly index) -> (a, b, twiddle).
module fft_addr_gen
    import fft_pkg::*;
(
    input  stage_t   s,
    input  k_t       k,
    output addr_t    a,
    output addr_t    b,
    output tw_addr_t tw
);
    addr_t span, grp, pos;

    always_comb begin
        span = addr_t'(1) << s;
        grp  = addr_t'(k) >> s;
        pos  = addr_t'(k) & (span - addr_t'(1));
        // Shift amount widened so s = 7 does not wrap to 0.
        a    = (grp << ({1'b0, s} + 4'd1)) | pos;
        b    = a + span;
        tw   = tw_addr_t'(pos << (stage_t'(LOG2N-1) - s));
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Drives one pipelined butterfly through all LOG2N stages of an in-place FFT,
// draining the pipe between stages so reads never overtake pending writes.
module fft_stage_sequencer
    import fft_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    fft_stage_sequencer_if.master bus
);
    localparam int DCW = $clog2(PIPE_LAT + 1);

    state_t               state_q, state_d;
    stage_t               s_q;
    k_t                   k_q;
    logic [DCW-1:0]       drain_q;
    logic                 rd_en, k_last, drain_last, s_last;
    addr_t                a, b;
    tw_addr_t             tw;
    logic [PIPE_LAT:1]    vld_pipe;
    addr_pair_t [PIPE_LAT:1] ad_pipe;
    logic                 err_q, mismatch;

    assign k_last     = (k_q == k_t'(NBF-1));
    assign drain_last = (drain_q == DCW'(PIPE_LAT-1));
    assign s_last     = (s_q == stage_t'(LOG2N-1));

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start) state_d = RUN;
            RUN:     if (k_last)      state_d = DRAIN;
            DRAIN:   if (drain_last)  state_d = s_last ? DONE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_en      = 1'b0;
        bus.o_busy = 1'b0;
        bus.o_done = 1'b0;
        case (state_q)
            RUN:     begin rd_en = 1'b1; bus.o_busy = 1'b1; end
            DRAIN:   bus.o_busy = 1'b1;
            DONE:    bus.o_done = 1'b1;
            default: ;
        endcase
    end

    // k wraps 127 -> 0 on its own, so leaving RUN already has k = 0.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.i_start) begin
                    s_q <= '0;
                    k_q <= '0;
                end
                RUN: begin
                    k_q     <= k_q + 1'b1;
                    drain_q <= '0;
                end
                DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_last && !s_last) begin
                        s_q <= s_q + 1'b1;
                        k_q <= '0;
                    end
                end
                default: ;
            endcase
        end

    fft_addr_gen u_addr_gen (
        .s  (s_q),
        .k  (k_q),
        .a  (a),
        .b  (b),
        .tw (tw)
    );

    // Addresses and expected-valid ride together so write-back lines up with i_bf_valid.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            vld_pipe <= '0;
            ad_pipe  <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[PIPE_LAT-1:1], rd_en};
            ad_pipe[1] <= {a, b};
            for (int i = 2; i <= PIPE_LAT; i++) ad_pipe[i] <= ad_pipe[i-1];
            err_q      <= err_q | mismatch;
        end

    assign mismatch = bus.i_bf_valid ^ vld_pipe[PIPE_LAT];

    assign bus.o_stage     = s_q;
    assign bus.o_rd_en     = rd_en;
    assign bus.o_rd_addr_a = rd_en ? a  : '0;
    assign bus.o_rd_addr_b = rd_en ? b  : '0;
    assign bus.o_tw_addr   = rd_en ? tw : '0;
    assign bus.o_bf_en     = vld_pipe[RD_LAT];
    assign bus.o_wr_en     = bus.i_bf_valid;
    assign bus.o_wr_addr_a = ad_pipe[PIPE_LAT].a;
    assign bus.o_wr_addr_b = ad_pipe[PIPE_LAT].b;
    assign bus.o_err       = err_q | mismatch;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: sequencer driving a behavioural RAM + butterfly through full 256-point frames.
module tb_fft_stage_sequencer;
    import fft_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    fft_stage_sequencer_if bus ();

    fft_stage_sequencer dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] ram [N];
    int          tw_re [NBF];
    int          tw_im [NBF];
    logic [31:0] qa, qb, p1x, p1y, p2x, p2y;
    logic [6:0]  qtw;
    logic        p1v, p2v;
    logic        ld, drop_now;
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // x' = x + W*y, y' = x - W*y, Q15 twiddle, no scaling.
    function automatic logic [63:0] bf(input logic [31:0] x, input logic [31:0] y, input logic [6:0] t);
        int xr, xi, yr, yi, pr, pim;
        xr  = int'($signed(x[31:16]));
        xi  = int'($signed(x[15:0]));
        yr  = int'($signed(y[31:16]));
        yi  = int'($signed(y[15:0]));
        pr  = (yr * tw_re[t] - yi * tw_im[t]) >>> 15;
        pim = (yr * tw_im[t] + yi * tw_re[t]) >>> 15;
        return {16'(xr + pr), 16'(xi + pim), 16'(xr - pr), 16'(xi - pim)};
    endfunction

    // Sync-read RAM/ROM (1 cycle) feeding a 2-stage butterfly.
    always @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            p1v <= 1'b0;
            p2v <= 1'b0;
        end else begin
            if (bus.o_rd_en) begin
                qa  <= ram[bus.o_rd_addr_a];
                qb  <= ram[bus.o_rd_addr_b];
                qtw <= bus.o_tw_addr;
            end
            p1v <= bus.o_bf_en;
            if (bus.o_bf_en) {p1x, p1y} <= bf(qa, qb, qtw);
            p2v <= p1v;
            p2x <= p1x;
            p2y <= p1y;
        end

    assign bus.i_bf_valid = p2v & ~drop_now;

    always @(posedge i_clk) begin
        if (ld) for (int i = 0; i < N; i++) ram[bitrev(i)] <= (i == 0) ? 32'h4000_0000 : 32'h0;
        else if (bus.o_wr_en) begin
            ram[bus.o_wr_addr_a] <= p2x;
            ram[bus.o_wr_addr_b] <= p2y;
        end
        if (bus.o_rd_en) rd_cnt   <= rd_cnt + 1;
        if (bus.o_wr_en) wr_cnt   <= wr_cnt + 1;
        if (bus.o_done)  done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_done"}, 32'(bus.o_done), 0);
        chk({tag, "_stage"}, 32'(bus.o_stage), 0);
        chk({tag, "_rd_en"}, 32'(bus.o_rd_en), 0);
        chk({tag, "_rd_ab"}, {16'h0, bus.o_rd_addr_a, bus.o_rd_addr_b}, 0);
        chk({tag, "_tw"}, 32'(bus.o_tw_addr), 0);
        chk({tag, "_bf_en"}, 32'(bus.o_bf_en), 0);
        chk({tag, "_wr"}, {15'h0, bus.o_wr_en, bus.o_wr_addr_a, bus.o_wr_addr_b}, 0);
        chk({tag, "_err"}, 32'(bus.o_err), 0);
    endtask

    int          n, done_n, bad;
    logic [2:0]  prev_st;

    initial begin
        for (int t = 0; t < NBF; t++) begin
            tw_re[t] =  $rtoi(32767.0 * $cos(2.0 * 3.14159265358979 * t / 256.0));
            tw_im[t] = -$rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * t / 256.0));
        end
        i_rst_n = 1'b0; bus.i_start = 1'b0; drop_now = 1'b0; ld = 1'b0;
        repeat (3) tick();
        chk_idle("reset");

        // Frame 1: impulse, directed address/timing checks, ignored starts.
        i_rst_n = 1'b1; ld = 1'b1; tick(); ld = 1'b0;
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
        n = 0; done_n = -1; prev_st = 3'd0;
        while (done_n < 0 && n < 1200) begin
            case (n)
                0: begin
                    chk("s0k0_rd_en", 32'(bus.o_rd_en), 1);
                    chk("s0k0_ab", {bus.o_rd_addr_a, bus.o_rd_addr_b}, {8'd0, 8'd1});
                    chk("s0k0_tw", 32'(bus.o_tw_addr), 0);
                    chk("s0k0_bf_en", 32'(bus.o_bf_en), 0);
                end
                1: begin
                    chk("s0k1_ab", {bus.o_rd_addr_a, bus.o_rd_addr_b}, {8'd2, 8'd3});
                    chk("s0k1_bf_en", 32'(bus.o_bf_en), 1);
                end
                2: chk("s0_wr_early", 32'(bus.o_wr_en), 0);
                3: begin
                    chk("s0_wr_en", 32'(bus.o_wr_en), 1);
                    chk("s0_wr_ab", {bus.o_wr_addr_a, bus.o_wr_addr_b}, {8'd0, 8'd1});
                end
                128: chk("drain_rd_busy", {bus.o_rd_en, bus.o_busy}, 32'b01);
                132: chk("s1k1", {5'(bus.o_stage), bus.o_rd_addr_a, bus.o_rd_addr_b, 1'b0, bus.o_tw_addr}, {5'd1, 8'd1, 8'd3, 8'd64});
                267: chk("s2k5", {5'(bus.o_stage), bus.o_rd_addr_a, bus.o_rd_addr_b, 1'b0, bus.o_tw_addr}, {5'd2, 8'd9, 8'd13, 8'd32});
                922: chk("s7k5", {5'(bus.o_stage), bus.o_rd_addr_a, bus.o_rd_addr_b, 1'b0, bus.o_tw_addr}, {5'd7, 8'd5, 8'd133, 8'd5});
                default: ;
            endcase
            if (bus.o_rd_en && bus.o_stage != prev_st) begin
                chk("hazard_pending_wr", 32'(rd_cnt - wr_cnt), 0);
                prev_st = bus.o_stage;
            end
            bus.i_start = (n == 443);
            tick(); n++;
            if (bus.o_done) done_n = n;
        end
        bus.i_start = 1'b0;
        chk("done_latency", 32'(done_n), 1048);
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
        chk("after_done_idle", {bus.o_busy, bus.o_done, bus.o_rd_en}, 0);
        repeat (5) tick();
        chk("start_in_done_ignored", 32'(bus.o_busy), 0);
        chk("done_pulses", 32'(done_cnt), 1);
        chk("frame1_err", 32'(bus.o_err), 0);
        bad = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== 32'h4000_0000) bad++;
        chk("bins_bad", 32'(bad), 0);
        chk("bin255", ram[255], 32'h4000_0000);

        // Frame 2: abort by reset at stage 4, k = 60.
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
        for (int i = 0; i < 584; i++) tick();
        chk("s4k60", {5'(bus.o_stage), bus.o_rd_addr_a, bus.o_rd_addr_b}, {5'd4, 8'd108, 8'd124});
        i_rst_n = 1'b0; tick();
        chk_idle("mid_reset");
        i_rst_n = 1'b1; tick();
        bus.i_start = 1'b1; tick(); bus.i_start = 1'b0;
        chk("restart", {bus.o_rd_en, 5'(bus.o_stage), bus.o_rd_addr_a, bus.o_rd_addr_b}, {1'b1, 5'd0, 8'd0, 8'd1});

        // Frame 3 (continuing): one dropped butterfly valid.
        n = 0; done_n = -1;
        while (done_n < 0 && n < 1200) begin
            drop_now = 1'b0;
            if (n == 19) chk("err_before_drop", 32'(bus.o_err), 0);
            if (n == 20) begin
                drop_now = 1'b1;
                #1;
                chk("err_on_drop", {bus.o_err, bus.o_wr_en}, 32'b10);
            end
            if (n == 21) chk("err_held", 32'(bus.o_err), 1);
            tick(); n++;
            if (bus.o_done) done_n = n;
        end
        drop_now = 1'b0;
        chk("frame3_latency", 32'(done_n), 1048);
        chk("err_at_done", 32'(bus.o_err), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
